toggle_cover_detector: RTL and testbench
========================================

// Module: toggle_cover_detector
// PURPOSE
// Upstream feeder for the GEN_w*_toggle DPI coverage sinks. Samples a WIDTH-bit probed signal and detects per-bit
// rising and falling edges. Emits a 2*WIDTH valid vector, one single-cycle pulse per edge event, to drive the sink.
// Optionally reports first-hit only, and keeps a covered bitmap, a hit count and an all-covered flag for run control.
// PARAMETERS
// WIDTH       1  number of probed signal bits; output has 2*WIDTH cover points
// FIRST_ONLY  1  1: pulse only on first hit of each point since reset/clear; 0: pulse on every edge
// CNT_W  $clog2(2*WIDTH+1)  width of covered_count (localparam, derived)
// PORTS
// clock          in   1         clock; all state updates on posedge
// reset          in   1         synchronous, active-low
// enable         in   1         sampling enable; while low, no events and prev sample held
// clear          in   1         clears covered bitmap/count, re-primes the sampler
// sig            in   WIDTH     probed signal
// valid          out  2*WIDTH   event pulses: [2i]=rise of sig[i], [2i+1]=fall of sig[i]; connects to sink valid
// covered        out  2*WIDTH   sticky bitmap of points hit since reset/clear
// covered_count  out  CNT_W     popcount of covered
// all_covered    out  1         covered == all ones
// BEHAVIOUR
// - Reset: reset is reset, synchronous, active-low; clock is clock. While reset==0 at a posedge:
//   state<=IDLE, prev<=0, valid<=0, covered<=0, covered_count<=0, all_covered<=0.
// - FSM (registered):
//   IDLE : enable=1 -> PRIME; no events.
//   PRIME: capture prev<=sig, no events; -> RUN if enable=1, else -> IDLE.
//   RUN  : enable=0 -> IDLE (prev held). Else per bit i: rise=~prev[i]&sig[i], fall=prev[i]&~sig[i]; prev<=sig.
// - The first sample after reset, clear, or re-enable never generates events (avoids false 0->X edges).
// - Events: raw = interleave(rise,fall); hit = FIRST_ONLY ? raw & ~covered : raw.
//   valid<=hit (registered). Pulse is visible the cycle after the posedge that saw the edge. Latency 1, width 1 cycle.
//   valid<=0 in every cycle not in RUN.
// - covered<=covered | raw. covered_count<=popcount(covered|raw), updated in the same cycle as covered.
//   all_covered<=&(covered|raw). Count never wraps: max value 2*WIDTH fits CNT_W.
// - clear=1 (any state, reset inactive): covered<=0, count<=0, all_covered<=0, valid<=0.
//   Then state<=PRIME if enable else IDLE. Events in that cycle are dropped.
//   clear has priority over event detection; reset has priority over clear.
// - Simultaneous rise on one bit and fall on another: both pulses in the same cycle; no arbitration needed.
// - Bit toggling every cycle: with FIRST_ONLY=0, its rise/fall pulses alternate every cycle.
// - Reset mid-RUN: all outputs 0 on the next cycle; in-flight pulses are discarded.
// - valid is meaningful only when the sink is out of reset. Sink and detector share clock and reset polarity
//   via the top-level adapter.
// STRUCTURE
// - Package toggle_cover_pkg holds:
//   * typedef enum logic [1:0] {IDLE, PRIME, RUN} tcd_state_t;
//   * function cnt_width(int w) = $clog2(2*w+1);
//   * localparam pair index helpers RISE_OFS=0, FALL_OFS=1.
// - Sub-module toggle_cover_cell: one per bit (generate loop).
//   * Holds prev and the 2 covered bits; outputs rise/fall hits; inputs run, prime, clear, first_only.
//   * Top keeps FSM, popcount (adder tree), all_covered.
// TESTING
// 1. Reset hold: reset=0 for 3 cycles with sig toggling -> valid/covered/covered_count/all_covered all 0.
// 2. Priming: WIDTH=4, enable 1 with sig=4'hF from first cycle -> no pulse on prime cycle;
//    sig 4'hF->4'h0 next -> valid=8'hAA one cycle later, covered_count=4.
// 3. FIRST_ONLY=1: bit0 toggles 0,1,0,1 -> valid[0] pulses once, valid[1] once, then no further pulses;
//    covered=8'h03, count=2.
// 4. FIRST_ONLY=0: bit1 toggles every cycle for 6 cycles -> valid[2]/valid[3] alternate each cycle;
//    count saturates at 2.
// 5. Full cover, WIDTH=2: sig 00->11->00 -> all_covered=1 with covered_count=4.
//    Then clear=1 -> count 0, all_covered 0, next sample primes with no pulse.
// 6. Enable/reset mid-run: drop enable during toggles -> valid 0. Re-enable with changed sig -> no pulse on prime.
//    Assert reset in RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle cover detector.
package toggle_cover_pkg;

    // Sampler FSM states: wait for enable, capture a baseline, then detect edges.
    typedef enum logic [1:0] {IDLE, PRIME, RUN} tcd_state_t;

    // Position of each edge kind inside a bit's two-entry cover-point pair.
    localparam int RISE_OFS = 0;
    localparam int FALL_OFS = 1;

    // Counter width able to hold every value from 0 to 2*w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/toggle_cover_cell.sv
// Per-bit edge detector: holds the previous sample and the two sticky cover bits.
module toggle_cover_cell
    import toggle_cover_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       prime,
    input  logic       clear,
    input  logic       first_only,
    input  logic       sig,
    output logic [1:0] hit,
    output logic [1:0] covered,
    output logic [1:0] covered_next
);

    logic       prev_reg;
    logic [1:0] covered_reg;
    logic [1:0] raw;

    // Raw edge events exist only while the sampler is running; hit masks already-covered points when asked.
    always_comb begin
        raw           = 2'b00;
        raw[RISE_OFS] = run & ~prev_reg & sig;
        raw[FALL_OFS] = run & prev_reg & ~sig;
        hit           = first_only ? (raw & ~covered_reg) : raw;
        covered_next  = clear ? 2'b00 : (covered_reg | raw);
    end

    // Baseline sample is refreshed on prime and on every running cycle; cover bits accumulate until clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_reg    <= 1'b0;
            covered_reg <= 2'b00;
        end else begin
            if (prime || run) begin
                prev_reg <= sig;
            end
            covered_reg <= covered_next;
        end
    end

    assign covered = covered_reg;

endmodule

// File: rtl/toggle_cover_detector.sv
// Toggle coverage feeder: per-bit rise/fall pulses, sticky cover bitmap, hit count and all-covered flag.
module toggle_cover_detector
    import toggle_cover_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit FIRST_ONLY = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               sig,
    output logic [2*WIDTH-1:0]             valid,
    output logic [2*WIDTH-1:0]             covered,
    output logic [cnt_width(WIDTH)-1:0]    covered_count,
    output logic                           all_covered
);

    localparam int CNT_W = cnt_width(WIDTH);

    tcd_state_t         state_reg;
    tcd_state_t         state_next;
    logic               run;
    logic               prime;
    logic [2*WIDTH-1:0] hit_vec;
    logic [2*WIDTH-1:0] covered_next_vec;
    logic [2*WIDTH-1:0] valid_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               all_covered_reg;

    // Next-state logic; clear overrides the normal flow and restarts from a fresh baseline.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   state_next = enable ? RUN : IDLE;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = enable ? PRIME : IDLE;
        end
    end

    // Cell strobes: events are dropped in a clear cycle, and nothing is sampled while disabled in RUN.
    always_comb begin
        run   = (state_reg == RUN) && enable && !clear;
        prime = (state_reg == PRIME) && !clear;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            toggle_cover_cell u_cell (
                .clock        (clock),
                .reset        (reset),
                .run          (run),
                .prime        (prime),
                .clear        (clear),
                .first_only   (FIRST_ONLY),
                .sig          (sig[gi]),
                .hit          (hit_vec[2*gi+1 -: 2]),
                .covered      (covered[2*gi+1 -: 2]),
                .covered_next (covered_next_vec[2*gi+1 -: 2])
            );
        end
    endgenerate

    // Population count of the cover bitmap as it will be after this edge.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            count_next = count_next + CNT_W'(covered_next_vec[i]);
        end
    end

    // FSM state and registered outputs; hit_vec is already zero outside a running, non-clear cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= IDLE;
            valid_reg       <= '0;
            count_reg       <= '0;
            all_covered_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            valid_reg       <= hit_vec;
            count_reg       <= count_next;
            all_covered_reg <= &covered_next_vec;
        end
    end

    assign valid         = valid_reg;
    assign covered_count = count_reg;
    assign all_covered   = all_covered_reg;

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Self-checking bench: directed vector table plus randomized run against a behavioural model.
module tb_toggle_cover_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sig_a = '0;
    logic [3:0] sig_b = '0;
    logic [1:0] sig_c = '0;

    logic [7:0] valid_a, covered_a, valid_b, covered_b;
    logic [3:0] valid_c, covered_c;
    logic [3:0] count_a, count_b;
    logic [2:0] count_c;
    logic       all_a, all_b, all_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    toggle_cover_detector #(.WIDTH(4), .FIRST_ONLY(1'b0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .sig(sig_a),
        .valid(valid_a), .covered(covered_a), .covered_count(count_a), .all_covered(all_a)
    );
    toggle_cover_detector #(.WIDTH(4), .FIRST_ONLY(1'b1)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .sig(sig_b),
        .valid(valid_b), .covered(covered_b), .covered_count(count_b), .all_covered(all_b)
    );
    toggle_cover_detector #(.WIDTH(2), .FIRST_ONLY(1'b1)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .sig(sig_c),
        .valid(valid_c), .covered(covered_c), .covered_count(count_c), .all_covered(all_c)
    );

    // Behavioural model: a detection window opens once enable has been seen on two
    // consecutive live edges since the last reset/clear/disable.
    int         streak;
    logic [3:0] last_m [3];
    logic [7:0] cov_m  [3];
    logic [7:0] val_m  [3];
    int         w_m    [3] = '{4, 4, 2};
    bit         fo_m   [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] mask_m [3] = '{8'hFF, 8'hFF, 8'h0F};

    task automatic model_edge();
        logic [3:0] s [3];
        logic [7:0] raw;
        s[0] = sig_a; s[1] = sig_b; s[2] = {2'b00, sig_c};
        for (int k = 0; k < 3; k++) begin
            if (!reset || clear || !enable || streak < 2) begin
                val_m[k] = '0;
                if (!reset || clear) cov_m[k] = '0;
            end else begin
                raw = '0;
                for (int b = 0; b < w_m[k]; b++) begin
                    if (!last_m[k][b] && s[k][b]) raw[2*b]   = 1'b1;
                    if (last_m[k][b] && !s[k][b]) raw[2*b+1] = 1'b1;
                end
                val_m[k] = fo_m[k] ? (raw & ~cov_m[k]) : raw;
                cov_m[k] = cov_m[k] | raw;
            end
            last_m[k] = s[k];
        end
        if (!reset)       streak = 0;
        else if (clear)   streak = enable ? 1 : 0;
        else if (!enable) streak = 0;
        else if (streak < 2) streak = streak + 1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic       rst_n, en, clr;
        logic [3:0] sa, sb;
        logic [1:0] sc;
        logic [7:0] va;
        logic [3:0] ca;
        logic [7:0] vb;
        logic [3:0] cb;
        logic [3:0] vc;
        logic       ac;
    } vec_t;

    vec_t tbl [22];

    initial begin
        streak = 0;
        for (int k = 0; k < 3; k++) begin
            last_m[k] = '0; cov_m[k] = '0; val_m[k] = '0;
        end

        //            rst en clr  sa     sb     sc     va     ca  vb     cb  vc     ac
        tbl[0]  = '{1'b0,1'b1,1'b0,4'hF,4'h0,2'h0,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,4'h0,4'h1,2'h3,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,4'hF,4'h0,2'h0,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,4'hF,4'h0,2'h0,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,4'hF,4'h0,2'h0,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b0,4'h0,4'h1,2'h3,8'hAA,4'd4,8'h01,4'd1,4'h5,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h0,8'h00,4'd4,8'h02,4'd2,4'hA,1'b1};
        tbl[7]  = '{1'b1,1'b1,1'b0,4'h0,4'h1,2'h0,8'h00,4'd4,8'h00,4'd2,4'h0,1'b1};
        tbl[8]  = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h0,8'h00,4'd4,8'h00,4'd2,4'h0,1'b1};
        tbl[9]  = '{1'b1,1'b1,1'b1,4'h2,4'h0,2'h0,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,4'h2,4'h0,2'h3,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h3,8'h08,4'd1,8'h00,4'd0,4'h0,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b0,4'h2,4'h0,2'h3,8'h04,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[13] = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h3,8'h08,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[14] = '{1'b1,1'b1,1'b0,4'h2,4'h0,2'h3,8'h04,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[15] = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h3,8'h08,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[16] = '{1'b1,1'b0,1'b0,4'h2,4'h0,2'h3,8'h00,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[17] = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h3,8'h00,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[18] = '{1'b1,1'b1,1'b0,4'h2,4'h0,2'h3,8'h00,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[19] = '{1'b1,1'b1,1'b0,4'h0,4'h0,2'h3,8'h08,4'd2,8'h00,4'd0,4'h0,1'b0};
        tbl[20] = '{1'b0,1'b1,1'b0,4'h2,4'h0,2'h3,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};
        tbl[21] = '{1'b1,1'b0,1'b0,4'h0,4'h0,2'h0,8'h00,4'd0,8'h00,4'd0,4'h0,1'b0};

        #2;
        for (int r = 0; r < 22; r++) begin
            reset = tbl[r].rst_n; enable = tbl[r].en; clear = tbl[r].clr;
            sig_a = tbl[r].sa; sig_b = tbl[r].sb; sig_c = tbl[r].sc;
            tick();
            $display("row %0d: rst=%b en=%b clr=%b sa=%h sb=%h sc=%h -> va=%h ca=%0d vb=%h cb=%0d vc=%h ac=%b",
                     r, reset, enable, clear, sig_a, sig_b, sig_c, valid_a, count_a, valid_b, count_b, valid_c, all_c);
            check("tbl_valid_a", valid_a, tbl[r].va);
            check("tbl_count_a", {4'h0, count_a}, {4'h0, tbl[r].ca});
            check("tbl_valid_b", valid_b, tbl[r].vb);
            check("tbl_count_b", {4'h0, count_b}, {4'h0, tbl[r].cb});
            check("tbl_valid_c", {4'h0, valid_c}, {4'h0, tbl[r].vc});
            check("tbl_all_c", {7'h0, all_c}, {7'h0, tbl[r].ac});
            if (r == 8) check("tbl_covered_b", covered_b, 8'h03);
            if (r == 6) check("tbl_count_c", {5'h0, count_c}, 8'd4);
        end

        // Randomized run against the model.
        reset = 1'b0;
        tick();
        for (int c = 0; c < 600; c++) begin
            reset  = ($urandom_range(0, 59) != 0);
            enable = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 24) == 0);
            sig_a  = 4'($urandom);
            sig_b  = 4'($urandom);
            sig_c  = 2'($urandom);
            tick();
            $display("cyc %0d: rst=%b en=%b clr=%b sa=%h sb=%h sc=%h -> va=%h vb=%h vc=%h cnt=%0d/%0d/%0d",
                     c, reset, enable, clear, sig_a, sig_b, sig_c, valid_a, valid_b, valid_c, count_a, count_b, count_c);
            check("rnd_valid_a", valid_a, val_m[0]);
            check("rnd_cov_a", covered_a, cov_m[0]);
            check("rnd_count_a", {4'h0, count_a}, 8'($countones(cov_m[0])));
            check("rnd_all_a", {7'h0, all_a}, {7'h0, cov_m[0] == mask_m[0]});
            check("rnd_valid_b", valid_b, val_m[1]);
            check("rnd_cov_b", covered_b, cov_m[1]);
            check("rnd_count_b", {4'h0, count_b}, 8'($countones(cov_m[1])));
            check("rnd_all_b", {7'h0, all_b}, {7'h0, cov_m[1] == mask_m[1]});
            check("rnd_valid_c", {4'h0, valid_c}, val_m[2]);
            check("rnd_cov_c", {4'h0, covered_c}, cov_m[2]);
            check("rnd_count_c", {5'h0, count_c}, 8'($countones(cov_m[2])));
            check("rnd_all_c", {7'h0, all_c}, {7'h0, cov_m[2] == mask_m[2]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
